// File: rtl/serial_adder_8_bits_if.sv
// Operand/result bundle for the bit-serial adder.
// The v port exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_8_bits_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             z;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             c;
`ifdef SERIAL_ADDER_OVF_EN
    logic             v;
`endif

    modport master (
        output start, x, y, z,
        input  busy, done, s, c
`ifdef SERIAL_ADDER_OVF_EN
        , input v
`endif
    );

    modport slave (
        input  start, x, y, z,
        output busy, done, s, c
`ifdef SERIAL_ADDER_OVF_EN
        , output v
`endif
    );
endinterface

// File: rtl/serial_adder_8_bits.sv
// Bit-serial ripple-carry adder: one full-adder cell, one carry flop, WIDTH cycles per add.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output v.
module serial_adder_8_bits #(
    parameter int WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    serial_adder_8_bits_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, res_q, s_q;
    logic             cy_q, c_q;
    logic [CW-1:0]    cnt_q;
    logic             accept, last_bit;
    logic             sum_bit, carry_nxt;
`ifdef SERIAL_ADDER_OVF_EN
    logic             v_q;
`endif

    // The single full-adder cell shared by every bit position.
    assign sum_bit   = a_q[0] ^ b_q[0] ^ cy_q;
    assign carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & cy_q) | (b_q[0] & cy_q);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        last_bit = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CW'(WIDTH - 1)) begin
                    last_bit = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: the datapath is only a handful of flops, so all of it is reset; an aborted add leaves no residue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            s_q   <= '0;
            cy_q  <= 1'b0;
            c_q   <= 1'b0;
            cnt_q <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            v_q   <= 1'b0;
`endif
        end else if (accept) begin
            a_q   <= bus.x;
            b_q   <= bus.y;
            cy_q  <= bus.z;
            cnt_q <= '0;
        end else if (state_q == RUN) begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            cy_q  <= carry_nxt;
            res_q <= {sum_bit, res_q[WIDTH-1:1]};
            cnt_q <= cnt_q + CW'(1);
            // Publish only on the final bit so s never shows a partial result.
            if (last_bit) begin
                s_q <= {sum_bit, res_q[WIDTH-1:1]};
                c_q <= carry_nxt;
`ifdef SERIAL_ADDER_OVF_EN
                v_q <= cy_q ^ carry_nxt;
`endif
            end
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.s    = s_q;
    assign bus.c    = c_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.v    = v_q;
`endif
endmodule
